// File: rtl/flunky_apb_arbiter.sv
// Round-robin arbiter and APB master sequencer for the shared flunkyfive
// slave port. Single-beat commands from NUM_REQ requesters are serialised
// into SETUP/ACCESS transfers; a one-cycle completion pulse with read data
// goes back to the requester that was granted.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; arbitrate, accept winner, latch its command
// SETUP  | psel=1, penable=0, latched command on paddr/pwrite/pwdata
// ACCESS | psel=1, penable=1, prdata captured at end of cycle
module flunky_apb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic                          psel,
    output logic                          penable,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    cand_idx;
    int                  cand;
    logic                any_valid;
    logic                accept;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_pend;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    // Round-robin search starting at rr_ptr; walking the offsets from the
    // far end down lets the nearest valid requester overwrite the others.
    always_comb begin
        winner    = rr_ptr;
        any_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (req_valid[cand_idx]) begin
                winner    = cand_idx;
                any_valid = 1'b1;
            end
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (winner == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = winner + 1'b1;
        end
    end

    // A command is taken only in IDLE; reset also masks the ready strobe so
    // every output reads zero while reset is held.
    assign accept = (state == IDLE) && any_valid && !reset;

    // Ready is a combinational one-hot strobe for the winner.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and APB strobes; reset forces IDLE so psel/penable drop at once.
    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel       = 1'b1;
                penable    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration pointer and grant index advance only on an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else if (accept) begin
            rr_ptr    <= rr_ptr_next;
            grant_idx <= winner;
        end
    end

    // Latch the winning command; write data is zeroed for reads so pwdata
    // never carries stale data on a read transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            write_q <= req_write[winner];
            wdata_q <= req_write[winner]
                     ? req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH]
                     : '0;
        end
    end

    assign paddr  = addr_q;
    assign pwrite = write_q;
    assign pwdata = wdata_q;

    // Completion pulse follows ACCESS by one cycle; read data is held only
    // for that cycle and is zero for writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_pend   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_pend   <= (state == ACCESS);
            rsp_data_q <= (state == ACCESS && !write_q) ? prdata : '0;
        end
    end

    // Steer the completion pulse to the granted requester.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_pend && (grant_idx == PTR_W'(i));
        end
    end

    assign rsp_rdata = rsp_data_q;

endmodule
